lin_slave_responder: RTL and testbench

- LIN slave-side header receiver and response transmitter, operating on 10-bit symbol frames: bit0 start=0, bits[8:1] data LSB-first, bit9 stop=1.
- Consumes the master's header symbol stream (break, sync, PID) and checks it.
- On a PID matching its published ID, sends DATA_LEN data bytes plus a checksum back toward the master as 10-bit frames.
- Sits inside the slave top, between the slave symbol interface and the application data buffer.

---
 rtl/lin_slave_responder_if.sv | 30 +++
 rtl/lin_slave_responder.sv | 163 ++++++++++++++++
 tb/tb_lin_slave_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lin_slave_responder_if.sv
// Symbol, response and buffer-write signals between a LIN slave responder and its surroundings.
// The slave modport is the responder's view; master is the view of whatever drives it.
interface lin_slave_responder_if;
  logic [9:0] rx_frame;
  logic       rx_valid;
  logic [9:0] tx_frame;
  logic       tx_valid;
  logic       tx_ready;
  logic       buf_wr_en;
  logic [2:0] buf_wr_addr;
  logic [7:0] buf_wr_data;
  logic       resp_active;
  logic [5:0] rx_pid;
  logic       frame_done;
  logic       parity_err;
  logic       sync_err;
  logic       framing_err;

  modport slave (
    input  rx_frame, rx_valid, tx_ready, buf_wr_en, buf_wr_addr, buf_wr_data,
    output tx_frame, tx_valid, resp_active, rx_pid, frame_done, parity_err,
           sync_err, framing_err
  );

  modport master (
    output rx_frame, rx_valid, tx_ready, buf_wr_en, buf_wr_addr, buf_wr_data,
    input  tx_frame, tx_valid, resp_active, rx_pid, frame_done, parity_err,
           sync_err, framing_err
  );
endinterface

// File: rtl/lin_slave_responder.sv
// LIN slave: checks break/sync/PID header and answers its own ID with buffered data plus checksum.
// Symbols are 10-bit frames {stop, data[7:0], start}.
module lin_slave_responder #(
  parameter logic [5:0] RESP_ID        = 6'h10,
  parameter int         DATA_LEN       = 2,
  parameter bit         ENHANCED_CKSUM = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  lin_slave_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_SYNC, WAIT_PID, TX_DATA, TX_CKSUM} state_t;

  localparam logic [9:0] SYM_BREAK = 10'h000;
  localparam logic [9:0] SYM_SYNC  = 10'h2AA;
  localparam logic [2:0] LAST_IDX  = 3'(DATA_LEN - 1);

  state_t     r_state, w_state_next;
  logic [2:0] r_idx, w_idx_next;
  logic [7:0] r_acc, w_acc_next;
  logic [5:0] r_rx_pid, w_rx_pid_next;
  logic       r_frame_done, w_frame_done_next;
  logic       r_parity_err, w_parity_err_next;
  logic       r_sync_err, w_sync_err_next;
  logic       r_framing_err, w_framing_err_next;
  logic [7:0] r_buf [8];

  logic       w_break;
  logic       w_well_formed;
  logic       w_parity_ok;
  logic       w_resp_active;
  logic       w_tx_hs;
  logic [5:0] w_id;
  logic [7:0] w_tx_byte;
  logic [8:0] w_sum9;
  logic [7:0] w_acc_add;

  assign w_break       = bus.rx_valid && (bus.rx_frame == SYM_BREAK);
  assign w_well_formed = !bus.rx_frame[0] && bus.rx_frame[9];
  assign w_id          = bus.rx_frame[6:1];
  assign w_parity_ok   = (bus.rx_frame[7] == (w_id[0] ^ w_id[1] ^ w_id[2] ^ w_id[4])) &&
                         (bus.rx_frame[8] == ~(w_id[1] ^ w_id[3] ^ w_id[4] ^ w_id[5]));
  assign w_resp_active = (r_state == TX_DATA) || (r_state == TX_CKSUM);
  assign w_tx_hs       = w_resp_active && bus.tx_ready;
  assign w_tx_byte     = r_buf[r_idx];
  // One's-complement style add: the carry out is folded back into bit 0.
  assign w_sum9        = {1'b0, r_acc} + {1'b0, w_tx_byte};
  assign w_acc_add     = w_sum9[7:0] + {7'd0, w_sum9[8]};

  // Buffer is frozen while a response is being sent so tx_frame cannot change under a stall.
  always_ff @(posedge clk) begin
    if (bus.buf_wr_en && !w_resp_active) begin
      r_buf[bus.buf_wr_addr] <= bus.buf_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_idx         <= 3'd0;
      r_acc         <= 8'd0;
      r_rx_pid      <= 6'd0;
      r_frame_done  <= 1'b0;
      r_parity_err  <= 1'b0;
      r_sync_err    <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_acc         <= w_acc_next;
      r_rx_pid      <= w_rx_pid_next;
      r_frame_done  <= w_frame_done_next;
      r_parity_err  <= w_parity_err_next;
      r_sync_err    <= w_sync_err_next;
      r_framing_err <= w_framing_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_acc_next         = r_acc;
    w_rx_pid_next      = r_rx_pid;
    w_frame_done_next  = 1'b0;
    w_parity_err_next  = 1'b0;
    w_sync_err_next    = 1'b0;
    w_framing_err_next = 1'b0;
    // A break restarts header reception from anywhere and wins over a pending handshake.
    if (w_break) begin
      w_state_next = WAIT_SYNC;
    end else begin
      unique case (r_state)
        IDLE: ;
        WAIT_SYNC: begin
          if (bus.rx_valid) begin
            if (!w_well_formed) begin
              w_framing_err_next = 1'b1;
              w_state_next       = IDLE;
            end else if (bus.rx_frame == SYM_SYNC) begin
              w_state_next = WAIT_PID;
            end else begin
              w_sync_err_next = 1'b1;
              w_state_next    = IDLE;
            end
          end
        end
        WAIT_PID: begin
          if (bus.rx_valid) begin
            w_state_next = IDLE;
            if (!w_well_formed) begin
              w_framing_err_next = 1'b1;
            end else if (!w_parity_ok) begin
              w_parity_err_next = 1'b1;
            end else begin
              w_rx_pid_next = w_id;
              if (w_id == RESP_ID) begin
                w_state_next = TX_DATA;
                w_idx_next   = 3'd0;
                w_acc_next   = ENHANCED_CKSUM ? bus.rx_frame[8:1] : 8'd0;
              end
            end
          end
        end
        TX_DATA: begin
          if (w_tx_hs) begin
            w_acc_next = w_acc_add;
            if (r_idx == LAST_IDX) begin
              w_state_next = TX_CKSUM;
            end else begin
              w_idx_next = r_idx + 3'd1;
            end
          end
        end
        TX_CKSUM: begin
          if (w_tx_hs) begin
            w_frame_done_next = 1'b1;
            w_state_next      = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.tx_frame = 10'h000;
    if (r_state == TX_DATA) begin
      bus.tx_frame = {1'b1, w_tx_byte, 1'b0};
    end else if (r_state == TX_CKSUM) begin
      bus.tx_frame = {1'b1, ~r_acc, 1'b0};
    end
  end

  assign bus.tx_valid    = w_resp_active;
  assign bus.resp_active = w_resp_active;
  assign bus.rx_pid      = r_rx_pid;
  assign bus.frame_done  = r_frame_done;
  assign bus.parity_err  = r_parity_err;
  assign bus.sync_err    = r_sync_err;
  assign bus.framing_err = r_framing_err;

endmodule

// File: tb/tb_lin_slave_responder.sv
// Scoreboard bench: enhanced and classic responders share stimulus; monitors pop expected
// frames and pulse events as the DUTs present them.
module tb_lin_slave_responder;
  localparam int         DLEN    = 2;
  localparam logic [9:0] SYM_BRK = 10'h000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] rx_frame = 10'h000;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;

  lin_slave_responder_if bus_e();
  lin_slave_responder_if bus_c();

  assign bus_e.rx_frame = rx_frame;    assign bus_c.rx_frame = rx_frame;
  assign bus_e.rx_valid = rx_valid;    assign bus_c.rx_valid = rx_valid;
  assign bus_e.tx_ready = tx_ready;    assign bus_c.tx_ready = tx_ready;
  assign bus_e.buf_wr_en = wr_en;      assign bus_c.buf_wr_en = wr_en;
  assign bus_e.buf_wr_addr = wr_addr;  assign bus_c.buf_wr_addr = wr_addr;
  assign bus_e.buf_wr_data = wr_data;  assign bus_c.buf_wr_data = wr_data;

  lin_slave_responder #(.RESP_ID(6'h10), .DATA_LEN(DLEN), .ENHANCED_CKSUM(1'b1)) dut_e (
    .clk(clk), .reset(reset), .bus(bus_e.slave));
  lin_slave_responder #(.RESP_ID(6'h10), .DATA_LEN(DLEN), .ENHANCED_CKSUM(1'b0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave));

  int n_tests = 0;
  int n_fail = 0;
  logic [9:0] exp_e[$];
  logic [9:0] exp_c[$];
  int ev_q[$];          // 1 done, 2 parity, 3 sync, 4 framing (enhanced DUT)
  int done_c = 0;       // pending frame_done pulses on the classic DUT
  logic [7:0] mbuf[8];
  logic [5:0] m_pid = 6'd0;
  bit stall = 1'b0;
  bit rand_ready = 1'b0;
  logic [9:0] want_e, want_c;
  int got_ev;
  logic [3:0] pulses_e;
  assign pulses_e = {bus_e.framing_err, bus_e.sync_err, bus_e.parity_err, bus_e.frame_done};

  function automatic string ev_name(input int k);
    case (k)
      1: return "frame_done";
      2: return "parity_err";
      3: return "sync_err";
      4: return "framing_err";
      default: return "none";
    endcase
  endfunction

  function automatic logic [7:0] pid_of(input logic [5:0] id);
    logic p0, p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  function automatic logic [9:0] fr(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // tx_ready is updated 2 time units after each rising edge, well clear of sampling.
  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  always @(negedge clk) begin
    if (bus_e.tx_valid && tx_ready) begin
      if (exp_e.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL enh_tx unexpected frame got=%0h want=none", bus_e.tx_frame);
      end else begin
        want_e = exp_e.pop_front();
        chk("enh_tx_frame", 32'(bus_e.tx_frame), 32'(want_e));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (pulses_e[k]) begin
        if (ev_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL enh_event got=%s want=none", ev_name(k + 1));
        end else begin
          got_ev = ev_q.pop_front();
          n_tests++;
          if (got_ev != k + 1) begin
            n_fail++;
            $display("FAIL enh_event got=%s want=%s", ev_name(k + 1), ev_name(got_ev));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_c.tx_valid && tx_ready) begin
      if (exp_c.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cls_tx unexpected frame got=%0h want=none", bus_c.tx_frame);
      end else begin
        want_c = exp_c.pop_front();
        chk("cls_tx_frame", 32'(bus_c.tx_frame), 32'(want_c));
      end
    end
    if (bus_c.frame_done) begin
      n_tests++;
      if (done_c == 0) begin
        n_fail++;
        $display("FAIL cls_frame_done got=1 want=0");
      end else begin
        done_c--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [9:0] f);
    rx_frame = f;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_frame = 10'h000;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input bit lands);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    if (lands) mbuf[a] = d;
  endtask

  // Expected response: data bytes, then NOT of the end-around-carry sum.
  task automatic expect_resp(input logic [7:0] pid);
    int se, sc;
    se = int'(pid);
    sc = 0;
    for (int i = 0; i < DLEN; i++) begin
      exp_e.push_back(fr(mbuf[i]));
      exp_c.push_back(fr(mbuf[i]));
      se += int'(mbuf[i]); if (se > 255) se -= 255;
      sc += int'(mbuf[i]); if (sc > 255) sc -= 255;
    end
    exp_e.push_back(fr(8'(255 - se)));
    exp_c.push_back(fr(8'(255 - sc)));
    ev_q.push_back(1);
    done_c++;
  endtask

  task automatic clear_expect();
    exp_e.delete();
    exp_c.delete();
    ev_q.delete();
    done_c = 0;
  endtask

  task automatic header(input logic [9:0] sync_f, input logic [9:0] pid_f, input bit wr_same,
                        input logic [2:0] wa, input logic [7:0] wd, output bit resp);
    bit sync_ok;
    resp = 1'b0;
    sync_ok = 1'b0;
    sym(SYM_BRK);
    if (sync_f[0] || !sync_f[9]) ev_q.push_back(4);
    else if (sync_f != 10'h2AA) ev_q.push_back(3);
    else sync_ok = 1'b1;
    sym(sync_f);
    if (wr_same) mbuf[wa] = wd;
    if (sync_ok) begin
      if (pid_f[0] || !pid_f[9]) ev_q.push_back(4);
      else if (pid_f[8:1] != pid_of(pid_f[6:1])) ev_q.push_back(2);
      else begin
        m_pid = pid_f[6:1];
        if (pid_f[6:1] == 6'h10) begin
          resp = 1'b1;
          expect_resp(pid_f[8:1]);
        end
      end
    end
    wr_en = wr_same; wr_addr = wa; wr_data = wd;
    sym(pid_f);
    wr_en = 1'b0;
    if (resp) chk("tx_latency", 32'(bus_e.tx_valid), 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_e.size() != 0 || exp_c.size() != 0 || ev_q.size() != 0 || done_c != 0) && c < 300) begin
      step();
      c++;
    end
    if (c >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_e.size() + ev_q.size());
      clear_expect();
    end
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    logic [5:0] id;
    logic [7:0] d;
    logic [9:0] sf, pf;
    int kind;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
    repeat (3) step();
    chk("reset_outputs", {bus_e.tx_valid, bus_e.resp_active, bus_e.tx_frame, bus_e.rx_pid,
                          pulses_e}, 32'd0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h00, 1'b1);

    wr(3'd0, 8'h12, 1'b1); wr(3'd1, 8'h34, 1'b1);
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    drain();
    chk("rx_pid_0x10", 32'(bus_e.rx_pid), 32'h10);

    wr(3'd0, 8'hFF, 1'b1); wr(3'd1, 8'h02, 1'b1);
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    drain();

    header(10'h2AA, 10'h220, 1'b0, 3'd0, 8'h00, r);
    drain();
    header(10'h2A8, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    drain();
    header(10'h2AB, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    drain();

    // Stall on byte 0, attempt a write while responding, then release.
    wr(3'd0, 8'h12, 1'b1); wr(3'd1, 8'h34, 1'b1);
    stall = 1'b1;
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    for (int i = 0; i < 5; i++) begin
      chk("stall_frame", 32'(bus_e.tx_frame), 32'h224);
      step();
    end
    wr(3'd0, 8'hEE, 1'b0);
    stall = 1'b0;
    drain();
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    drain();

    // Break after byte 0 has been accepted.
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    step();
    stall = 1'b1;
    step(); step();
    sym(SYM_BRK);
    clear_expect();
    chk("break_abort_valid", 32'(bus_e.tx_valid), 32'd0);
    stall = 1'b0;
    repeat (4) step();
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    drain();

    header(10'h2AA, fr(pid_of(6'h11)), 1'b0, 3'd0, 8'h00, r);
    drain();
    chk("rx_pid_0x11", 32'(bus_e.rx_pid), 32'h11);

    header(10'h2AA, 10'h2A0, 1'b1, 3'd1, 8'h77, r);
    drain();

    // Reset in the middle of a response.
    stall = 1'b1;
    header(10'h2AA, 10'h2A0, 1'b0, 3'd0, 8'h00, r);
    reset = 1'b0;
    step();
    clear_expect();
    m_pid = 6'd0;
    chk("midreset_state", {bus_e.tx_valid, bus_e.resp_active, bus_e.rx_pid}, 32'd0);
    reset = 1'b1;
    stall = 1'b0;
    step();

    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) wr(3'($urandom_range(0, 7)), 8'($urandom), 1'b1);
      kind = $urandom_range(0, 5);
      id = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'($urandom);
      sf = 10'h2AA;
      pf = fr(pid_of(id));
      case (kind)
        3: pf[7] = ~pf[7];
        4: begin
          d = 8'($urandom);
          if (d == 8'h55) d = 8'h56;
          sf = fr(d);
        end
        5: if ($urandom_range(0, 1) == 1) sf[0] = 1'b1; else pf[0] = 1'b1;
        default: ;
      endcase
      header(sf, pf, 1'($urandom_range(0, 1)), 3'($urandom_range(0, DLEN - 1)), 8'($urandom), r);
      drain();
      chk("rand_rx_pid", 32'(bus_e.rx_pid), 32'(m_pid));
    end
    rand_ready = 1'b0;

    chk("queues_empty", 32'(exp_e.size() + exp_c.size() + ev_q.size() + done_c), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
